rate_counter: RTL
=================

Name: rate_counter

Overview:
- Parametrised successor to the LED up-counter path: a WIDTH-bit counter with up, down, bounce and hold modes, synchronous load, and terminal-count flagging.
- Runs entirely on FastClk. An internal prescaler generates a count-enable tick at a software-selectable rate, replacing the switch-muxed divided clock; no derived or gated clocks.
- Sits between board switches/buttons and the LED bank in the top level.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- RATE_SEL_W, 2, width of RateSel; 2^RATE_SEL_W selectable rates.
- BASE_SHIFT, 20, log2 of the tick period at RateSel=0.
- RATE_STEP, 2, log2 increment of the tick period per RateSel step.

Ports:
- FastClk  input  1  system clock; all logic on rising edge.
- Reset_n  input  1  synchronous active-low reset.
- Enable  input  1  count enable, qualified by tick.
- Mode  input  2  00 up, 01 down, 10 bounce, 11 hold.
- RateSel  input  RATE_SEL_W  tick-rate select.
- Load  input  1  synchronous load strobe.
- LoadVal  input  WIDTH  value loaded on Load.
- Count  output  WIDTH  current count, registered.
- Dir  output  1  current direction, 1=up, 0=down; registered.
- TermCount  output  1  one-cycle pulse on wrap or reversal.
- Tick  output  1  internal count-enable tick, for debug/LED.

Behaviour:
- Reset (Reset_n=0 at clock edge) sets Count=0, Dir=1, TermCount=0, prescaler=0 and Tick=0. Reset has highest priority.
- Prescaler:
  - Free-running counter of width PW = BASE_SHIFT + (2^RATE_SEL_W - 1)*RATE_STEP (minimum 1). It runs regardless of Enable, Mode or Load.
  - N = BASE_SHIFT + RateSel*RATE_STEP.
  - Tick is combinational: 1 when prescaler[N-1:0] are all ones. For N=0, Tick=1 every cycle.
  - Tick period is 2^N cycles.
  - A RateSel change takes effect on the next cycle with no prescaler reset, so the first tick after a change may arrive early.
- Priority per edge: reset > Load > (Tick & Enable) counting step.
- Load: Count <= LoadVal on the edge where Load=1, independent of Tick.
  - Dir is unchanged, except in mode 10: Dir <= 1 if LoadVal==0, Dir <= 0 if LoadVal==MAX.
  - TermCount=0 in the following cycle.
- Counting step (Tick & Enable & !Load), MAX = 2^WIDTH-1:
  - Mode 00: Dir <= 1. Count <= Count+1 modulo 2^WIDTH. MAX->0 wraps and asserts TermCount.
  - Mode 01: Dir <= 0. Count <= Count-1 modulo 2^WIDTH. 0->MAX wraps and asserts TermCount.
  - Mode 10:
    - Count steps in direction Dir.
    - Stepping up from MAX-1 to MAX sets Dir <= 0 and asserts TermCount.
    - Stepping down from 1 to 0 sets Dir <= 1 and asserts TermCount.
    - Count never wraps in this mode.
    - If entered while Count is at an endpoint with Dir pointing outward, the first step reverses: Dir flips and Count moves inward by 1, with no TermCount.
  - Mode 11: Count and Dir held; TermCount=0.
- Timing:
  - TermCount is registered: high exactly one cycle, the cycle after the edge that performed the wrap or reversal. Otherwise 0.
  - Count updates one cycle after the qualifying edge.
- Boundary conditions:
  - Enable=0: Count and Dir frozen; Tick still toggles.
  - A Mode change mid-run applies at the next step.
  - Reset asserted mid-count clears on that edge regardless of Tick or Load.

Optional Feature:
- Macro: RATE_COUNTER_STICKY_TC_EN.
- Defined: TermCount is a sticky flag. It is set by any wrap/reversal event, stays 1 until Load or reset, and Load clears it.
- Undefined: TermCount is the one-cycle pulse described above. Default.

Test Plan:
- WIDTH=3, BASE_SHIFT=0, RATE_STEP=1, RateSel=0, Mode=00, Enable=1 from reset -> Count 0,1,...,7,0 on consecutive cycles; TermCount=1 only in the cycle Count=0 after 7.
- Same config, RateSel=2 -> Tick every 4th cycle; Count increments every 4 cycles; Enable=0 for 8 cycles -> Count frozen while Tick keeps pulsing.
- Mode=01 after Load with LoadVal=1 -> Count 1,0,7; TermCount pulses once at 0->7; Dir=0.
- Mode=10 from Count=5, Dir=1 -> 6,7,6,...,1,0,1; TermCount pulses after reaching 7 and after reaching 0; Dir flips at those points.
- Load=1 with LoadVal=3 on a Tick&Enable cycle -> Count=3, not 4. Reset_n=0 on the same edge as Load -> Count=0, Dir=1.
- With RATE_COUNTER_STICKY_TC_EN, Mode=00 wrap 7->0 -> TermCount stays 1 through subsequent counts until Load clears it.

Source files
------------

// File: rtl/rate_counter.sv
// Prescaled up/down/bounce/hold counter with load and terminal-count flag, all on FastClk.
// Build option RATE_COUNTER_STICKY_TC_EN: TermCount latches until Load or reset instead of pulsing.
module rate_counter #(
  parameter int WIDTH      = 4,
  parameter int RATE_SEL_W = 2,
  parameter int BASE_SHIFT = 20,
  parameter int RATE_STEP  = 2
) (
  input  logic                  FastClk,
  input  logic                  Reset_n,
  input  logic                  Enable,
  input  logic [1:0]            Mode,
  input  logic [RATE_SEL_W-1:0] RateSel,
  input  logic                  Load,
  input  logic [WIDTH-1:0]      LoadVal,
  output logic [WIDTH-1:0]      Count,
  output logic                  Dir,
  output logic                  TermCount,
  output logic                  Tick
);

  localparam int PW_RAW = BASE_SHIFT + ((1 << RATE_SEL_W) - 1) * RATE_STEP;
  localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;

  localparam logic [WIDTH-1:0] ZERO   = '0;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH-1:0] MAX_M1 = MAX - ONE;

  logic [PW-1:0]    presc;
  logic [PW-1:0]    mask;
  int               n;
  logic             tick_raw;
  logic [WIDTH-1:0] cnt_nxt;
  logic             dir_nxt;
  logic             evt;

  // Tick fires when the low N prescaler bits are all ones; N=0 gives an empty mask, i.e. every cycle.
  always_comb begin
    mask = '0;
    n    = BASE_SHIFT + RATE_STEP * int'(RateSel);
    for (int i = 0; i < PW; i++) begin
      mask[i] = (i < n);
    end
    tick_raw = ((presc & mask) == mask);
  end

  assign Tick = Reset_n & tick_raw;

  always_comb begin
    cnt_nxt = Count;
    dir_nxt = Dir;
    evt     = 1'b0;
    if (Load) begin
      cnt_nxt = LoadVal;
      if (Mode == 2'b10) begin
        if (LoadVal == ZERO)     dir_nxt = 1'b1;
        else if (LoadVal == MAX) dir_nxt = 1'b0;
      end
    end else if (tick_raw && Enable) begin
      case (Mode)
        2'b00: begin
          dir_nxt = 1'b1;
          cnt_nxt = Count + ONE;
          evt     = (Count == MAX);
        end
        2'b01: begin
          dir_nxt = 1'b0;
          cnt_nxt = Count - ONE;
          evt     = (Count == ZERO);
        end
        2'b10: begin
          // Sitting on an endpoint while pointing outward: turn around silently.
          if (Dir) begin
            if (Count == MAX) begin
              dir_nxt = 1'b0;
              cnt_nxt = Count - ONE;
            end else begin
              cnt_nxt = Count + ONE;
              if (Count == MAX_M1) begin
                dir_nxt = 1'b0;
                evt     = 1'b1;
              end
            end
          end else begin
            if (Count == ZERO) begin
              dir_nxt = 1'b1;
              cnt_nxt = Count + ONE;
            end else begin
              cnt_nxt = Count - ONE;
              if (Count == ONE) begin
                dir_nxt = 1'b1;
                evt     = 1'b1;
              end
            end
          end
        end
        default: begin
          cnt_nxt = Count;
          dir_nxt = Dir;
        end
      endcase
    end
  end

  always_ff @(posedge FastClk) begin
    if (!Reset_n) begin
      presc     <= '0;
      Count     <= '0;
      Dir       <= 1'b1;
      TermCount <= 1'b0;
    end else begin
      presc <= presc + PW'(1);
      Count <= cnt_nxt;
      Dir   <= dir_nxt;
`ifdef RATE_COUNTER_STICKY_TC_EN
      if (Load)     TermCount <= 1'b0;
      else if (evt) TermCount <= 1'b1;
`else
      TermCount <= evt;
`endif
    end
  end

endmodule
